// File: rtl/rsa_pkg.sv
// Shared types for the RSA private-exponent sequencer.
// States, error codes and operand word types.
package rsa_pkg;

    localparam int WORD_WIDTH = 32;

    typedef logic [WORD_WIDTH-1:0] word_t;
    typedef logic signed [WORD_WIDTH-1:0] sword_t;

    typedef enum logic [3:0] {
        IDLE,
        CHECK,
        LAUNCH,
        WAIT,
        RELEASE,
        EVAL,
        FIXUP,
        DONE,
        ERR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_INPUT,
        ERR_EXHAUSTED,
        ERR_TIMEOUT
    } err_code_t;

endpackage

// File: rtl/rsa_exponent_ctrl_if.sv
// Key-setup request bundle and GCD engine bundle.
// master drives the request side, slave answers it.
interface rsa_key_if #(
    parameter int W  = 32,
    parameter int TW = 5
);
    logic          start;
    logic [W-1:0]  phi;
    logic [W-1:0]  e_init;
    logic          busy;
    logic          done;
    logic          error;
    logic [1:0]    err_code;
    logic [W-1:0]  e_out;
    logic [W-1:0]  d_out;
    logic [TW-1:0] tries;

    modport master (
        output start, phi, e_init,
        input  busy, done, error, err_code,
        input  e_out, d_out, tries
    );
    modport slave (
        input  start, phi, e_init,
        output busy, done, error, err_code,
        output e_out, d_out, tries
    );
endinterface

interface rsa_gcd_if #(
    parameter int W = 32
);
    logic         gcd_enable;
    logic [W-1:0] gcd_x;
    logic [W-1:0] gcd_y;
    logic         gcd_done;
    logic [W-1:0] gcd_result;
    logic [W-1:0] gcd_coeff_i;

    modport master (
        output gcd_enable, gcd_x, gcd_y,
        input  gcd_done, gcd_result, gcd_coeff_i
    );
    modport slave (
        input  gcd_enable, gcd_x, gcd_y,
        output gcd_done, gcd_result, gcd_coeff_i
    );
endinterface

// File: rtl/rsa_mod_normalize.sv
// Maps a signed Bezout coefficient into [0, phi).
// Assumes |coeff| < phi and phi < 2^(W-1).
module rsa_mod_normalize #(
    parameter int W = 32
) (
    input  logic [W-1:0] coeff,
    input  logic [W-1:0] phi,
    output logic [W-1:0] d
);
    logic [W:0] sum;
    logic [W:0] red;

    always_comb begin
        sum = coeff[W-1] ? ({coeff[W-1], coeff} + {1'b0, phi})
                         : {1'b0, coeff};
        red = sum - {1'b0, phi};
        d   = (sum >= {1'b0, phi}) ? red[W-1:0] : sum[W-1:0];
    end
endmodule

// File: rtl/rsa_exponent_ctrl.sv
// Derives d = e^-1 mod phi by driving an extended binary GCD engine,
// stepping e through odd candidates until gcd(e, phi) == 1.
module rsa_exponent_ctrl
    import rsa_pkg::*;
#(
    parameter int WORD_WIDTH     = 32,
    parameter int MAX_TRIES      = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic      clk,
    input  logic      reset,
    rsa_key_if.slave  key,
    rsa_gcd_if.master gcd
);
    localparam int W  = WORD_WIDTH;
    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam int DW = $clog2(TIMEOUT_CYCLES);

    state_t        state;
    logic [W-1:0]  phi_q;
    logic [W-1:0]  e_q;
    logic [W-1:0]  res_q;
    logic [W-1:0]  coeff_q;
    logic [W-1:0]  d_norm;
    logic [TW-1:0] tries_q;
    logic [DW-1:0] wd;
    logic [W:0]    e_next;
    logic          bad_in;
    logic          last_try;

    assign e_next   = {1'b0, e_q} + (W+1)'(2);
    assign bad_in   = phi_q[W-1] | (phi_q < W'(4)) | ~e_q[0]
                    | (e_q < W'(3)) | (e_q >= phi_q);
    assign last_try = (tries_q == TW'(MAX_TRIES))
                    | (e_next >= {1'b0, phi_q});
    assign key.tries = tries_q;

    rsa_mod_normalize #(.W(W)) u_norm (
        .coeff (coeff_q),
        .phi   (phi_q),
        .d     (d_norm)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            key.busy       <= 1'b0;
            key.done       <= 1'b0;
            key.error      <= 1'b0;
            key.err_code   <= ERR_NONE;
            key.e_out      <= '0;
            key.d_out      <= '0;
            gcd.gcd_enable <= 1'b0;
            gcd.gcd_x      <= '0;
            gcd.gcd_y      <= '0;
            phi_q          <= '0;
            e_q            <= '0;
            res_q          <= '0;
            coeff_q        <= '0;
            tries_q        <= '0;
            wd             <= '0;
        end else begin
            key.done  <= 1'b0;
            key.error <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (key.start) begin
                        phi_q        <= key.phi;
                        e_q          <= key.e_init;
                        tries_q      <= '0;
                        key.err_code <= ERR_NONE;
                        key.busy     <= 1'b1;
                        state        <= CHECK;
                    end
                end
                CHECK: begin
                    if (bad_in) begin
                        key.error    <= 1'b1;
                        key.err_code <= ERR_INPUT;
                        key.busy     <= 1'b0;
                        state        <= ERR;
                    end else begin
                        state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    gcd.gcd_x      <= e_q;
                    gcd.gcd_y      <= phi_q;
                    gcd.gcd_enable <= 1'b1;
                    tries_q        <= tries_q + TW'(1);
                    wd             <= '0;
                    state          <= WAIT;
                end
                WAIT: begin
                    wd <= wd + DW'(1);
                    if (gcd.gcd_done) begin
                        res_q          <= gcd.gcd_result;
                        coeff_q        <= gcd.gcd_coeff_i;
                        gcd.gcd_enable <= 1'b0;
                        state          <= RELEASE;
                    end else if (wd == DW'(TIMEOUT_CYCLES - 1)) begin
                        gcd.gcd_enable <= 1'b0;
                        key.error      <= 1'b1;
                        key.err_code   <= ERR_TIMEOUT;
                        key.busy       <= 1'b0;
                        state          <= ERR;
                    end
                end
                // enable is already low here, giving the engine its idle cycle
                RELEASE: state <= EVAL;
                EVAL: begin
                    if (res_q == W'(1)) begin
                        state <= FIXUP;
                    end else if (last_try) begin
                        key.error    <= 1'b1;
                        key.err_code <= ERR_EXHAUSTED;
                        key.busy     <= 1'b0;
                        state        <= ERR;
                    end else begin
                        e_q   <= e_next[W-1:0];
                        state <= LAUNCH;
                    end
                end
                FIXUP: begin
                    key.e_out <= e_q;
                    key.d_out <= d_norm;
                    key.done  <= 1'b1;
                    key.busy  <= 1'b0;
                    state     <= DONE;
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rsa_exponent_ctrl.sv
// Directed bench for rsa_exponent_ctrl with a behavioural GCD engine.
// Engine modes: 0 = extended Euclid, 1 = forced result, 2 = never done.
module tb_rsa_exponent_ctrl;
    import rsa_pkg::*;

    localparam int LAT = 4;

    typedef struct {
        logic [31:0] phi;
        logic [31:0] e;
        int          mode;
        logic [31:0] fg;
        logic [31:0] fc;
        bit          ok;
        logic [1:0]  code;
        logic [31:0] ee;
        logic [31:0] ed;
        int          et;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rsa_key_if #(.W(32), .TW(5)) ka ();
    rsa_gcd_if #(.W(32))         ga ();
    rsa_key_if #(.W(32), .TW(2)) kb ();
    rsa_gcd_if #(.W(32))         gb ();

    rsa_exponent_ctrl #(
        .WORD_WIDTH     (32),
        .MAX_TRIES      (16),
        .TIMEOUT_CYCLES (64)
    ) dut_a (
        .clk   (clk),
        .reset (rst_n),
        .key   (ka.slave),
        .gcd   (ga.master)
    );

    rsa_exponent_ctrl #(
        .WORD_WIDTH     (32),
        .MAX_TRIES      (2),
        .TIMEOUT_CYCLES (64)
    ) dut_b (
        .clk   (clk),
        .reset (rst_n),
        .key   (kb.slave),
        .gcd   (gb.master)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int mode = 0;
    logic [31:0] f_gcd = '0;
    logic [31:0] f_coeff = '0;

    function automatic logic [63:0] xgcd(input logic [31:0] a,
                                         input logic [31:0] b);
        longint r0, r1, s0, s1, q, t;
        r0 = {32'd0, a};
        r1 = {32'd0, b};
        s0 = 1;
        s1 = 0;
        while (r1 != 0) begin
            q  = r0 / r1;
            t  = r0 - q * r1;
            r0 = r1;
            r1 = t;
            t  = s0 - q * s1;
            s0 = s1;
            s1 = t;
        end
        return {r0[31:0], s0[31:0]};
    endfunction

    logic [63:0] xa, xb;
    always_comb xa = xgcd(ga.gcd_x, ga.gcd_y);
    always_comb xb = xgcd(gb.gcd_x, gb.gcd_y);

    int cnt_a = 0;
    bit fired_a = 1'b0;
    always @(posedge clk) begin
        ga.gcd_done <= 1'b0;
        if (ga.gcd_enable !== 1'b1) begin
            cnt_a   <= 0;
            fired_a <= 1'b0;
        end else if (!fired_a) begin
            if (cnt_a == LAT) begin
                fired_a         <= 1'b1;
                ga.gcd_done     <= (mode != 2);
                ga.gcd_result   <= (mode == 1) ? f_gcd : xa[63:32];
                ga.gcd_coeff_i  <= (mode == 1) ? f_coeff : xa[31:0];
            end else begin
                cnt_a <= cnt_a + 1;
            end
        end
    end

    int cnt_b = 0;
    bit fired_b = 1'b0;
    always @(posedge clk) begin
        gb.gcd_done <= 1'b0;
        if (gb.gcd_enable !== 1'b1) begin
            cnt_b   <= 0;
            fired_b <= 1'b0;
        end else if (!fired_b) begin
            if (cnt_b == LAT) begin
                fired_b        <= 1'b1;
                gb.gcd_done    <= 1'b1;
                gb.gcd_result  <= xb[63:32];
                gb.gcd_coeff_i <= xb[31:0];
            end else begin
                cnt_b <= cnt_b + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_a(input vec_t v, input int idx);
        int  cyc;
        int  en_cyc;
        bit  seen_en;
        bit  fin;
        string p;
        p = $sformatf("v%0d", idx);
        mode    = v.mode;
        f_gcd   = v.fg;
        f_coeff = v.fc;
        ka.phi    = v.phi;
        ka.e_init = v.e;
        ka.start  = 1'b1;
        @(negedge clk);
        ka.start = 1'b0;
        chk({p, " busy_after_start"}, 64'(ka.busy), 1);
        cyc = 0;
        en_cyc = 0;
        seen_en = 1'b0;
        fin = 1'b0;
        while (!fin && cyc < 3000) begin
            if (ga.gcd_enable === 1'b1 && !seen_en) begin
                seen_en = 1'b1;
                en_cyc  = cyc;
            end
            if (ka.done === 1'b1 || ka.error === 1'b1) begin
                fin = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk({p, " finished"}, 64'(fin), 1);
        chk({p, " done"}, 64'(ka.done), 64'(v.ok));
        chk({p, " error"}, 64'(ka.error), 64'(!v.ok));
        chk({p, " busy_at_pulse"}, 64'(ka.busy), 0);
        if (!v.ok)
            chk({p, " err_code"}, 64'(ka.err_code), 64'(v.code));
        chk({p, " e_out"}, 64'(ka.e_out), 64'(v.ee));
        chk({p, " d_out"}, 64'(ka.d_out), 64'(v.ed));
        chk({p, " tries"}, 64'(ka.tries), 64'(v.et));
        if (!v.ok && v.code == 2'd1) begin
            chk({p, " no_enable"}, 64'(seen_en), 0);
            chk({p, " err_latency"}, 64'(cyc), 1);
        end
        if (!v.ok && v.code == 2'd3) begin
            chk({p, " timeout_window"},
                64'((cyc - en_cyc) >= 63 && (cyc - en_cyc) <= 66), 1);
        end
        @(negedge clk);
        chk({p, " pulse_end"}, 64'(ka.done | ka.error), 0);
    endtask

    vec_t vecs[14];

    initial begin
        int  cyc;
        bit  fin;

        vecs[0]  = '{32'd3120, 32'd17, 0, 0, 0,
                     1'b1, 2'd0, 32'd17, 32'd2753, 1};
        vecs[1]  = '{32'd3120, 32'd3, 0, 0, 0,
                     1'b1, 2'd0, 32'd7, 32'd1783, 3};
        vecs[2]  = '{32'd3120, 32'd17, 1, 32'd1, 32'hFFFF_FE91,
                     1'b1, 2'd0, 32'd17, 32'd2753, 1};
        vecs[3]  = '{32'd3120, 32'd17, 1, 32'd1, 32'd2753,
                     1'b1, 2'd0, 32'd17, 32'd2753, 1};
        vecs[4]  = '{32'd3120, 32'd16, 0, 0, 0,
                     1'b0, 2'd1, 32'd17, 32'd2753, 0};
        vecs[5]  = '{32'h8000_0010, 32'd17, 0, 0, 0,
                     1'b0, 2'd1, 32'd17, 32'd2753, 0};
        vecs[6]  = '{32'd3120, 32'd1, 0, 0, 0,
                     1'b0, 2'd1, 32'd17, 32'd2753, 0};
        vecs[7]  = '{32'd3120, 32'd3121, 0, 0, 0,
                     1'b0, 2'd1, 32'd17, 32'd2753, 0};
        vecs[8]  = '{32'd3, 32'd3, 0, 0, 0,
                     1'b0, 2'd1, 32'd17, 32'd2753, 0};
        vecs[9]  = '{32'd10, 32'd5, 0, 0, 0,
                     1'b1, 2'd0, 32'd7, 32'd3, 2};
        vecs[10] = '{32'd3120, 32'd17, 2, 0, 0,
                     1'b0, 2'd3, 32'd7, 32'd3, 1};
        vecs[11] = '{32'd3120, 32'd3119, 1, 32'd5, 0,
                     1'b0, 2'd2, 32'd7, 32'd3, 1};
        vecs[12] = '{32'd3120, 32'd3, 1, 32'd3, 0,
                     1'b0, 2'd2, 32'd7, 32'd3, 16};
        vecs[13] = '{32'd9, 32'd3, 0, 0, 0,
                     1'b1, 2'd0, 32'd5, 32'd2, 2};

        ka.start = 1'b0;
        ka.phi = '0;
        ka.e_init = '0;
        kb.start = 1'b0;
        kb.phi = '0;
        kb.e_init = '0;
        repeat (3) @(negedge clk);

        chk("rst busy", 64'(ka.busy), 0);
        chk("rst done", 64'(ka.done), 0);
        chk("rst error", 64'(ka.error), 0);
        chk("rst enable", 64'(ga.gcd_enable), 0);
        chk("rst e_out", 64'(ka.e_out), 0);
        chk("rst d_out", 64'(ka.d_out), 0);
        chk("rst tries", 64'(ka.tries), 0);
        chk("rst gcd_x", 64'(ga.gcd_x), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++)
            run_a(vecs[i], i);

        // MAX_TRIES=2: gcd(3,3120)=3, gcd(5,3120)=5, then give up
        kb.phi = 32'd3120;
        kb.e_init = 32'd3;
        kb.start = 1'b1;
        @(negedge clk);
        kb.start = 1'b0;
        cyc = 0;
        fin = 1'b0;
        while (!fin && cyc < 3000) begin
            if (kb.done === 1'b1 || kb.error === 1'b1) fin = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("b finished", 64'(fin), 1);
        chk("b error", 64'(kb.error), 1);
        chk("b done", 64'(kb.done), 0);
        chk("b err_code", 64'(kb.err_code), 2);
        chk("b tries", 64'(kb.tries), 2);

        // reset while the engine is busy
        mode = 0;
        ka.phi = 32'd3120;
        ka.e_init = 32'd17;
        ka.start = 1'b1;
        @(negedge clk);
        ka.start = 1'b0;
        cyc = 0;
        while (ga.gcd_enable !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid enable_up", 64'(ga.gcd_enable), 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid rst enable", 64'(ga.gcd_enable), 0);
        chk("mid rst busy", 64'(ka.busy), 0);
        chk("mid rst state", 64'(dut_a.state), 64'(IDLE));
        chk("mid rst e_out", 64'(ka.e_out), 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_a(vecs[0], 99);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_cmp, n_fail);
        $finish;
    end
endmodule
